fetch_pc_gen: RTL and testbench

- Fetch-stage next-PC generator; sits directly upstream of the BTB and drives its read address (pc_out).
- Holds the architectural fetch PC and issues instruction-memory reads with a read/resp handshake.
- Owns a 2-bit saturating branch history table (BHT). It combines the BHT prediction with the BTB target to choose the next PC.
- Accepts mispredict redirects and BHT training updates from EX.

---
 rtl/rv32i_types.sv | 15 +
 rtl/fetch_pc_gen_bht.sv | 32 +++
 rtl/fetch_pc_gen.sv | 86 ++++++++
 tb/tb_fetch_pc_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared fetch-stage types, constants and the BHT saturating-counter helper.
package rv32i_types;

    typedef enum logic {FETCH, DRAIN} fetch_state_t;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t    BHT_WEAK_NT = 2'b01;
    localparam logic [31:0] PC_INC      = 32'd4;

    function automatic bht_ctr_t bht_sat(input bht_ctr_t c, input logic taken);
        return taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
    endfunction

endpackage

// File: rtl/fetch_pc_gen_bht.sv
// bht_counter_array: 2^IDX two-bit saturating counters, combinational read, synchronous update.
module bht_counter_array
    import rv32i_types::*;
#(
    parameter int IDX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rd_idx,
    output bht_ctr_t       rd_ctr,
    input  logic           wr_en,
    input  logic [IDX-1:0] wr_idx,
    input  logic           wr_taken
);

    localparam int DEPTH = 1 << IDX;

    bht_ctr_t ctr [DEPTH];

    assign rd_ctr = ctr[rd_idx];

    // Per-entry registers keep the async reset of the whole table a plain flop reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                ctr[i] <= BHT_WEAK_NT;
            else if (wr_en && wr_idx == IDX'(i))
                ctr[i] <= bht_sat(ctr[i], wr_taken);
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register with BHT/BTB next-PC prediction and mispredict redirect handling.
module fetch_pc_gen
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          BHT_IDX  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] btb_target,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] pc_out,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    output logic        fetch_valid,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc
);

    fetch_state_t state, state_d;
    logic [31:0]  pc_d, pending_pc, pending_d;
    logic         read_q, resp;
    bht_ctr_t     ctr;
    logic         unused_ok;

    assign unused_ok = ^{btb_target[1:0], upd_pc[31:BHT_IDX+2], upd_pc[1:0]};

    bht_counter_array #(.IDX(BHT_IDX)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (pc_out[BHT_IDX+1:2]),
        .rd_ctr   (ctr),
        .wr_en    (upd_valid),
        .wr_idx   (upd_pc[BHT_IDX+1:2]),
        .wr_taken (upd_taken)
    );

    // A response only counts while a request is actually outstanding.
    assign resp         = imem_resp && read_q;
    assign pred_taken   = ctr[1] && (btb_target != '0);
    assign pred_next_pc = pred_taken ? {btb_target[31:2], 2'b00} : pc_out + PC_INC;
    assign imem_read    = read_q;
    assign imem_addr    = pc_out;
    assign fetch_valid  = (state == FETCH) && resp && !redirect;

    always_comb begin
        state_d   = state;
        pc_d      = pc_out;
        pending_d = pending_pc;
        if (state == FETCH) begin
            if (redirect && (resp || !read_q)) begin
                pc_d = redirect_pc;
            end else if (redirect) begin
                pending_d = redirect_pc;
                state_d   = DRAIN;
            end else if (resp && !stall) begin
                pc_d = pred_next_pc;
            end
        end else begin
            pending_d = redirect ? redirect_pc : pending_pc;
            pc_d      = resp ? pending_d : pc_out;
            state_d   = resp ? FETCH : DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc_out     <= RESET_PC;
            pending_pc <= RESET_PC;
            read_q     <= 1'b0;
        end else begin
            state      <= state_d;
            pc_out     <= pc_d;
            pending_pc <= pending_d;
            read_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed self-checking bench for fetch_pc_gen.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] btb_target;
    logic        imem_resp;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] pc_out;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        fetch_valid;
    logic        pred_taken;
    logic [31:0] pred_next_pc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_pc_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btb_target   (btb_target),
        .imem_resp    (imem_resp),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .pc_out       (pc_out),
        .imem_read    (imem_read),
        .imem_addr    (imem_addr),
        .fetch_valid  (fetch_valid),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; btb_target = '0; imem_resp = 1'b1; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        tick(); tick();
        chk("rst_pc", pc_out, 32'h60);
        chk("rst_read", {31'b0, imem_read}, 0);
        chk("rst_fv", {31'b0, fetch_valid}, 0);
        #3 rst_n = 1'b1;
        #1 chk("read_before_edge", {31'b0, imem_read}, 0);
        tick();
        chk("read_after_edge", {31'b0, imem_read}, 1);
        chk("pc_60", pc_out, 32'h60);
        chk("fv_60", {31'b0, fetch_valid}, 1);
        chk("pt_60", {31'b0, pred_taken}, 0);
        chk("pnp_60", pred_next_pc, 32'h64);
        tick(); chk("pc_64", pc_out, 32'h64); chk("fv_64", {31'b0, fetch_valid}, 1);
        tick(); chk("pc_68", pc_out, 32'h68); chk("addr_68", imem_addr, 32'h68);
        tick(); tick();
        chk("pc_70", pc_out, 32'h70);
        // stall holds the PC while responses keep arriving
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_fv", {31'b0, fetch_valid}, 1);
            tick(); chk("stall_pc", pc_out, 32'h70);
        end
        stall = 1'b0;
        tick(); chk("after_stall_pc", pc_out, 32'h74);
        // train 0x80 taken three times while fetch is idle
        imem_resp = 1'b0; upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1;
        tick(); tick(); tick();
        chk("idle_pc", pc_out, 32'h74);
        upd_valid = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h80; imem_resp = 1'b1;
        #1 chk("redir_squash", {31'b0, fetch_valid}, 0);
        tick(); redirect = 1'b0;
        chk("pc_80", pc_out, 32'h80);
        btb_target = 32'h200;
        #1 chk("pt_80_taken", {31'b0, pred_taken}, 1);
        chk("pnp_80_taken", pred_next_pc, 32'h200);
        tick(); chk("pc_200", pc_out, 32'h200);
        // untrain back to strongly not-taken
        imem_resp = 1'b0; upd_valid = 1'b1; upd_taken = 1'b0;
        tick(); tick(); tick();
        upd_valid = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h80; imem_resp = 1'b1;
        tick(); redirect = 1'b0;
        #1 chk("pt_80_nt", {31'b0, pred_taken}, 0);
        chk("pnp_80_nt", pred_next_pc, 32'h84);
        tick(); chk("pc_84", pc_out, 32'h84);
        // one taken update from 00 only reaches 01: still not-taken
        upd_valid = 1'b1; upd_taken = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        tick(); upd_valid = 1'b0; redirect = 1'b0;
        #1 chk("sat_low", {31'b0, pred_taken}, 0);
        // redirect while a request is outstanding drains first
        btb_target = '0; redirect = 1'b1; redirect_pc = 32'h90;
        tick(); chk("pc_90", pc_out, 32'h90);
        imem_resp = 1'b0; redirect_pc = 32'h400;
        #1 chk("drain_enter_fv", {31'b0, fetch_valid}, 0);
        tick(); redirect = 1'b0;
        chk("drain_addr", imem_addr, 32'h90);
        chk("drain_read", {31'b0, imem_read}, 1);
        tick(); chk("drain_hold", imem_addr, 32'h90);
        imem_resp = 1'b1;
        #1 chk("drain_fv", {31'b0, fetch_valid}, 0);
        tick(); chk("pc_400", pc_out, 32'h400);
        #1 chk("fv_400", {31'b0, fetch_valid}, 1);
        redirect = 1'b1; redirect_pc = 32'h500;
        #1 chk("redir500_fv", {31'b0, fetch_valid}, 0);
        tick(); chk("pc_500", pc_out, 32'h500);
        // redirect beats stall; BHT update lands in the same cycle
        stall = 1'b1; redirect_pc = 32'h600; upd_valid = 1'b1; upd_pc = 32'h600; upd_taken = 1'b1;
        tick(); redirect = 1'b0; stall = 1'b0; upd_valid = 1'b0;
        chk("pc_600", pc_out, 32'h600);
        btb_target = 32'h703;
        #1 chk("pt_600", {31'b0, pred_taken}, 1);
        chk("pnp_600", pred_next_pc, 32'h700);
        btb_target = '0;
        // newest redirect during DRAIN wins
        imem_resp = 1'b0; redirect = 1'b1; redirect_pc = 32'h700;
        tick(); redirect_pc = 32'h800;
        tick(); redirect = 1'b0; imem_resp = 1'b1;
        tick(); chk("pc_newest", pc_out, 32'h800);
        imem_resp = 1'b0; redirect = 1'b1; redirect_pc = 32'h900;
        tick(); redirect = 1'b0;
        chk("drain_again", pc_out, 32'h800);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_pc", pc_out, 32'h60);
        chk("async_rst_read", {31'b0, imem_read}, 0);
        tick(); #2 rst_n = 1'b1;
        imem_resp = 1'b1;
        tick();
        chk("post_rst_pc", pc_out, 32'h60);
        chk("post_rst_fv", {31'b0, fetch_valid}, 1);
        redirect = 1'b1; redirect_pc = 32'h600;
        tick(); redirect = 1'b0;
        chk("post_rst_600", pc_out, 32'h600);
        btb_target = 32'h700;
        #1 chk("post_rst_bht", {31'b0, pred_taken}, 0);
        chk("post_rst_pnp", pred_next_pc, 32'h604);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
